rename_alloc_ctrl: RTL and testbench

RENAME_ALLOC_CTRL -- requirements
Module: rename_alloc_ctrl

---
 rtl/rename_pkg.sv | 13 +
 rtl/rename_alloc_ptr.sv | 12 +
 rtl/rename_alloc_ctrl.sv | 113 +++++++++++
 tb/tb_rename_alloc_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared defaults and FSM state encoding for the rename allocation controller.
package rename_pkg;
  localparam int NCOMMIT_DEF  = 32;
  localparam int LNCOMMIT_DEF = 5;
  localparam int NALLOC_DEF   = 8;
  localparam int LNALLOC_DEF  = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RELOAD1 = 2'd1,
    RELOAD2 = 2'd2
  } alloc_state_t;
endpackage

// File: rtl/rename_alloc_ptr.sv
// Modular ring-pointer add or distance (a+b or a-b, wrapping mod 2**W).
// Latency: combinational. Backpressure: none.
module rename_alloc_ptr #(
  parameter int W = 5
) (
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);
  assign result = sub ? (a - b) : (a + b);
endmodule

// File: rtl/rename_alloc_ctrl.sv
// Commit-station allocator: grants rename slots all-or-nothing, tracks retire, rewinds on flush.
// Latency: grant/stall same clock, pointers next clock. Backpressure: alloc_stall when space short; 2-clock bubble after flush.
// Optional macro RENAME_ALLOC_STATS_EN adds saturating stall/reload cycle counters.
module rename_alloc_ctrl
  import rename_pkg::*;
#(
  parameter int NCOMMIT  = NCOMMIT_DEF,
  parameter int LNCOMMIT = LNCOMMIT_DEF,
  parameter int NALLOC   = NALLOC_DEF,
  parameter int LNALLOC  = LNALLOC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LNALLOC-1:0]  alloc_req,
  input  logic [LNALLOC-1:0]  retire_count,
  input  logic                flush,
  input  logic [LNCOMMIT-1:0] flush_end,
  output logic [LNCOMMIT-1:0] next_start,
  output logic [LNALLOC-1:0]  alloc_grant,
  output logic [LNCOMMIT:0]   current_available,
  output logic                alloc_stall,
  output logic                rename_reloading,
`ifdef RENAME_ALLOC_STATS_EN
  output logic [31:0]         stat_stall_cycles,
  output logic [31:0]         stat_reload_cycles,
`endif
  output logic                empty,
  output logic                full
);
  localparam int CW = LNCOMMIT + 1;

  alloc_state_t        state_q, state_d;
  logic [LNCOMMIT-1:0] oldest_q, next_start_q;
  logic [LNCOMMIT-1:0] oldest_d, next_start_d;
  logic [CW-1:0]       in_use_q, in_use_d;
  logic [CW-1:0]       req_ext, retire_ext, retire_eff, grant_ext, flush_dist_ext;
  logic [LNCOMMIT-1:0] next_start_sum, oldest_sum, flush_dist;
  logic                grant_ok, req_legal;

  assign current_available = CW'(NCOMMIT) - in_use_q;
  assign next_start        = next_start_q;
  assign empty             = (in_use_q == '0);
  assign full              = (in_use_q == CW'(NCOMMIT));

  assign req_ext    = CW'(alloc_req);
  assign retire_ext = CW'(retire_count);
  assign retire_eff = (retire_ext < in_use_q) ? retire_ext : in_use_q;
  assign req_legal  = (req_ext <= CW'(NALLOC));

  // Availability deliberately uses the pre-retire count.
  assign grant_ok    = !reset && !flush && (state_q == RUN);
  assign alloc_grant = (grant_ok && req_legal && (req_ext <= current_available)) ? alloc_req : '0;
  assign alloc_stall = grant_ok && (req_ext > current_available);
  assign grant_ext   = CW'(alloc_grant);

  rename_alloc_ptr #(.W(LNCOMMIT)) u_next_ptr (
    .sub(1'b0), .a(next_start_q), .b(LNCOMMIT'(alloc_grant)), .result(next_start_sum)
  );
  // retire_eff can equal NCOMMIT; truncation is the correct modular step.
  rename_alloc_ptr #(.W(LNCOMMIT)) u_oldest_ptr (
    .sub(1'b0), .a(oldest_q), .b(retire_eff[LNCOMMIT-1:0]), .result(oldest_sum)
  );
  rename_alloc_ptr #(.W(LNCOMMIT)) u_flush_dist (
    .sub(1'b1), .a(flush_end), .b(oldest_q), .result(flush_dist)
  );
  assign flush_dist_ext = CW'(flush_dist);

  always_comb begin
    state_d          = state_q;
    rename_reloading = !reset && (state_q != RUN);
    next_start_d     = next_start_sum;
    oldest_d         = oldest_sum;
    in_use_d         = in_use_q + grant_ext - retire_eff;
    case (state_q)
      RELOAD1: state_d = RELOAD2;
      RELOAD2: state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) begin
      state_d      = RELOAD1;
      next_start_d = flush_end;
      in_use_d     = (flush_dist_ext > retire_eff) ? (flush_dist_ext - retire_eff) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      oldest_q     <= '0;
      next_start_q <= '0;
      in_use_q     <= '0;
    end else begin
      state_q      <= state_d;
      oldest_q     <= oldest_d;
      next_start_q <= next_start_d;
      in_use_q     <= in_use_d;
    end
  end

`ifdef RENAME_ALLOC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cycles  <= '0;
      stat_reload_cycles <= '0;
    end else begin
      if (alloc_stall && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (rename_reloading && (stat_reload_cycles != '1))
        stat_reload_cycles <= stat_reload_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed self-checking bench for rename_alloc_ctrl (default parameters, NCOMMIT=32).
module tb_rename_alloc_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alloc_req;
  logic [3:0] retire_count;
  logic       flush;
  logic [4:0] flush_end;
  logic [4:0] next_start;
  logic [3:0] alloc_grant;
  logic [5:0] current_available;
  logic       alloc_stall;
  logic       rename_reloading;
  logic       empty;
  logic       full;
`ifdef RENAME_ALLOC_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_reload_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rename_alloc_ctrl dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .retire_count(retire_count),
    .flush(flush), .flush_end(flush_end), .next_start(next_start),
    .alloc_grant(alloc_grant), .current_available(current_available),
    .alloc_stall(alloc_stall), .rename_reloading(rename_reloading),
`ifdef RENAME_ALLOC_STATS_EN
    .stat_stall_cycles(stat_stall_cycles), .stat_reload_cycles(stat_reload_cycles),
`endif
    .empty(empty), .full(full)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; alloc_req = 4'd5; retire_count = 4'd3; flush = 1'b0; flush_end = 5'd7;
    cyc; cyc;
    chk("rst_grant", alloc_grant, 0);
    chk("rst_stall", alloc_stall, 0);
    chk("rst_reload", rename_reloading, 0);
    chk("rst_avail", current_available, 32);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_next", next_start, 0);

    // Fill: four grants of 8
    reset = 1'b0; alloc_req = 4'd8; retire_count = 4'd0; flush_end = 5'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_grant", alloc_grant, 8);
      chk("fill_next", next_start, i * 8);
      cyc;
    end
    chk("fill_full", full, 1);
    chk("fill_avail", current_available, 0);

    // Full with retire: refused this clock, accepted the next
    alloc_req = 4'd1; retire_count = 4'd3; #1;
    chk("full_ret_grant", alloc_grant, 0);
    chk("full_ret_stall", alloc_stall, 1);
    cyc;
    retire_count = 4'd0; #1;
    chk("post_ret_avail", current_available, 3);
    chk("post_ret_grant", alloc_grant, 1);
    cyc;
    chk("post_ret_next", next_start, 1);
    chk("post_ret_avail2", current_available, 2);

    // Drain with excess retire ignored
    alloc_req = 4'd0; retire_count = 4'd15;
    cyc; chk("drain_avail1", current_available, 17);
    cyc; chk("drain_avail2", current_available, 32);
    chk("drain_empty", empty, 1);
    retire_count = 4'd8;
    cyc; chk("excess_ret_avail", current_available, 32);

    // Move oldest/next_start to 28, then wrap
    retire_count = 4'd0; alloc_req = 4'd8;
    cyc; cyc; cyc;
    alloc_req = 4'd3; cyc;
    chk("pre_wrap_next", next_start, 28);
    chk("pre_wrap_avail", current_available, 5);
    alloc_req = 4'd0; retire_count = 4'd15; cyc;
    retire_count = 4'd12; cyc;
    chk("pre_wrap_empty", empty, 1);
    alloc_req = 4'd8; retire_count = 4'd0; #1;
    chk("wrap_grant", alloc_grant, 8);
    cyc;
    chk("wrap_next", next_start, 4);
    chk("wrap_avail", current_available, 24);
    alloc_req = 4'd0; retire_count = 4'd8; cyc;
    chk("wrap_ret_empty", empty, 1);

    // Flush: in_use 20 from oldest 0, flush_end 5, retire 2
    reset = 1'b1; retire_count = 4'd0; cyc; reset = 1'b0;
    alloc_req = 4'd8; cyc; cyc;
    alloc_req = 4'd4; cyc;
    chk("pre_flush_avail", current_available, 12);
    chk("pre_flush_next", next_start, 20);
    flush = 1'b1; flush_end = 5'd5; retire_count = 4'd2; alloc_req = 4'd8; #1;
    chk("flush_grant", alloc_grant, 0);
    chk("flush_stall", alloc_stall, 0);
    cyc;
    flush = 1'b0; retire_count = 4'd1; #1;
    chk("rl1_reload", rename_reloading, 1);
    chk("rl1_next", next_start, 5);
    chk("rl1_avail", current_available, 29);
    chk("rl1_grant", alloc_grant, 0);
    cyc;
    retire_count = 4'd0; #1;
    chk("rl2_reload", rename_reloading, 1);
    chk("rl2_avail", current_available, 30);
    chk("rl2_grant", alloc_grant, 0);
    cyc;
    chk("run_reload", rename_reloading, 0);
    chk("run_grant", alloc_grant, 8);
    chk("run_next", next_start, 5);
    cyc;
    chk("run_next2", next_start, 13);
    chk("run_avail2", current_available, 22);

    // Flush again while in RELOAD2 restarts the bubble
    alloc_req = 4'd0; flush = 1'b1; flush_end = 5'd13; cyc;
    flush = 1'b0; #1;
    chk("rf_rl1", rename_reloading, 1);
    chk("rf_avail", current_available, 22);
    cyc;
    flush = 1'b1; flush_end = 5'd8; #1;
    chk("rf_rl2", rename_reloading, 1);
    cyc;
    flush = 1'b0; #1;
    chk("rf2_rl1", rename_reloading, 1);
    chk("rf2_next", next_start, 8);
    chk("rf2_avail", current_available, 27);
    cyc; chk("rf2_rl2", rename_reloading, 1);
    cyc; chk("rf2_run", rename_reloading, 0);

    // flush_end == oldest kills everything
    flush = 1'b1; flush_end = 5'd3; cyc;
    flush = 1'b0; #1;
    chk("kill_empty", empty, 1);
    chk("kill_full", full, 0);
    chk("kill_next", next_start, 3);

    // Reset in RELOAD1 abandons the bubble
    reset = 1'b1; alloc_req = 4'd8; #1;
    chk("rst_rl_grant", alloc_grant, 0);
    chk("rst_rl_reload", rename_reloading, 0);
    cyc;
    reset = 1'b0; #1;
    chk("rst_rl_run", rename_reloading, 0);
    chk("rst_rl_next", next_start, 0);
    chk("rst_rl_avail", current_available, 32);
    chk("rst_rl_grant2", alloc_grant, 8);
    cyc; cyc; cyc; cyc;
    chk("refill_full", full, 1);

    // Three stall clocks, then a flush that empties a full ring
    alloc_req = 4'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_loop", alloc_stall, 1);
      cyc;
    end
    flush = 1'b1; flush_end = 5'd0; cyc;
    flush = 1'b0;
    chk("full_kill_empty", empty, 1);
    chk("full_kill_full", full, 0);
    cyc; cyc;
    chk("stat_run", rename_reloading, 0);
`ifdef RENAME_ALLOC_STATS_EN
    chk("stat_stall", stat_stall_cycles, 3);
    chk("stat_reload", stat_reload_cycles, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
